alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one combinational ALU between two requesters. An op is granted and
// latched into the alu_* registers (IDLE), the ALU return is captured one cycle
// later (EXEC), and the response is held for the owning requester until it is
// taken (RESP).
//
// Configuration macro: ALU_ARBITER_RR_EN
//   defined   : round-robin on ties, the requester not served last wins
//   undefined : fixed priority, requester 0 wins ties (no pointer state)
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   reqN_valid/ready               request handshake, N in {0,1}
//   reqN_unit/sub_unit/sel         op encoding
//   reqN_rs1/rs2/immediate         operands
//   reqN_rd, reqN_imm              destination tag, immediate operand select
//   rspN_valid/ready               response handshake, N in {0,1}
//   rsp_result/branch/rd/illegal   shared response payload
//   alu_*                          registered op presented to the ALU
//   alu_ok/result_v/branch/result  combinational ALU return
// -----------------------------------------------------------------------------
module alu_arbiter #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req0_valid,
   output logic            req0_ready,
   input  logic [1:0]      req0_unit,
   input  logic [2:0]      req0_sub_unit,
   input  logic [3:0]      req0_sel,
   input  logic [XLEN-1:0] req0_rs1,
   input  logic [XLEN-1:0] req0_rs2,
   input  logic [XLEN-1:0] req0_immediate,
   input  logic [4:0]      req0_rd,
   input  logic            req0_imm,
   input  logic            req1_valid,
   output logic            req1_ready,
   input  logic [1:0]      req1_unit,
   input  logic [2:0]      req1_sub_unit,
   input  logic [3:0]      req1_sel,
   input  logic [XLEN-1:0] req1_rs1,
   input  logic [XLEN-1:0] req1_rs2,
   input  logic [XLEN-1:0] req1_immediate,
   input  logic [4:0]      req1_rd,
   input  logic            req1_imm,
   output logic            rsp0_valid,
   input  logic            rsp0_ready,
   output logic            rsp1_valid,
   input  logic            rsp1_ready,
   output logic [XLEN-1:0] rsp_result,
   output logic            rsp_branch,
   output logic [4:0]      rsp_rd,
   output logic            rsp_illegal,
   output logic [1:0]      alu_unit,
   output logic [2:0]      alu_sub_unit,
   output logic [3:0]      alu_sel,
   output logic [XLEN-1:0] alu_rs1,
   output logic [XLEN-1:0] alu_rs2,
   output logic [XLEN-1:0] alu_immediate,
   output logic [4:0]      alu_rd,
   output logic            alu_imm,
   input  logic            alu_ok,
   input  logic            alu_result_v,
   input  logic            alu_branch,
   input  logic [XLEN-1:0] alu_result
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state_r;
   state_t state_nxt_s;
   logic   grant0_s;
   logic   grant1_s;
   logic   accept0_s;
   logic   accept1_s;
   logic   accept_s;
   logic   rsp_hs_s;
   logic   owner_r;

`ifdef ALU_ARBITER_RR_EN
   // Last-served pointer: 1 means requester 1 was served last, so 0 wins a tie.
   logic   ptr_r;

   // Round-robin grant: on a tie the requester not served last wins.
   always_comb begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
      if (req0_valid && req1_valid) begin
         grant0_s = ptr_r;
         grant1_s = ~ptr_r;
      end else begin
         grant0_s = req0_valid;
         grant1_s = req1_valid;
      end
   end

   // Pointer moves only when an op is actually accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_r <= 1'b1;
      end else if (accept0_s) begin
         ptr_r <= 1'b0;
      end else if (accept1_s) begin
         ptr_r <= 1'b1;
      end
   end
`else
   // Fixed-priority grant: requester 0 always wins a tie.
   always_comb begin
      grant0_s = req0_valid;
      grant1_s = req1_valid & ~req0_valid;
   end
`endif

   // Ready only in IDLE for the granted requester; forced low while in reset.
   always_comb begin
      req0_ready = (state_r == IDLE) & ~rst & grant0_s;
      req1_ready = (state_r == IDLE) & ~rst & grant1_s;
      accept0_s  = req0_valid & req0_ready;
      accept1_s  = req1_valid & req1_ready;
      accept_s   = accept0_s | accept1_s;
      rsp_hs_s   = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next state: EXEC always lasts exactly one cycle.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_nxt_s = EXEC;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         EXEC: state_nxt_s = RESP;
         RESP: begin
            if (rsp_hs_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = RESP;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Op registers: load on accept, otherwise hold the last accepted op.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_unit      <= 2'd0;
         alu_sub_unit  <= 3'd0;
         alu_sel       <= 4'd0;
         alu_rs1       <= '0;
         alu_rs2       <= '0;
         alu_immediate <= '0;
         alu_rd        <= 5'd0;
         alu_imm       <= 1'b0;
         owner_r       <= 1'b0;
      end else if (accept1_s) begin
         alu_unit      <= req1_unit;
         alu_sub_unit  <= req1_sub_unit;
         alu_sel       <= req1_sel;
         alu_rs1       <= req1_rs1;
         alu_rs2       <= req1_rs2;
         alu_immediate <= req1_immediate;
         alu_rd        <= req1_rd;
         alu_imm       <= req1_imm;
         owner_r       <= 1'b1;
      end else if (accept0_s) begin
         alu_unit      <= req0_unit;
         alu_sub_unit  <= req0_sub_unit;
         alu_sel       <= req0_sel;
         alu_rs1       <= req0_rs1;
         alu_rs2       <= req0_rs2;
         alu_immediate <= req0_immediate;
         alu_rd        <= req0_rd;
         alu_imm       <= req0_imm;
         owner_r       <= 1'b0;
      end
   end

   // Response payload: captured from the ALU in EXEC and held through RESP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_result  <= '0;
         rsp_branch  <= 1'b0;
         rsp_rd      <= 5'd0;
         rsp_illegal <= 1'b0;
      end else if (state_r == EXEC) begin
         rsp_result  <= alu_result;
         rsp_branch  <= alu_branch;
         rsp_rd      <= alu_rd;
         rsp_illegal <= ~alu_result_v | ~alu_ok;
      end
   end

   // Response valid: raised for the owner entering RESP, dropped on handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
      end else if (state_r == EXEC) begin
         rsp0_valid <= ~owner_r;
         rsp1_valid <= owner_r;
      end else if (rsp_hs_s) begin
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Directed vectors for alu_arbiter with a scoreboard: each issued op pushes its
// hand-computed response into a queue, and a monitor pops and compares on every
// response handshake. A small behavioural ALU answers the registered alu_* op.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

   localparam int XLEN = 32;

   typedef struct {
      logic        port;
      logic [31:0] result;
      logic        branch;
      logic [4:0]  rd;
      logic        illegal;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            req0_valid, req0_ready, req1_valid, req1_ready;
   logic [1:0]      req0_unit, req1_unit;
   logic [2:0]      req0_sub_unit, req1_sub_unit;
   logic [3:0]      req0_sel, req1_sel;
   logic [XLEN-1:0] req0_rs1, req0_rs2, req0_immediate;
   logic [XLEN-1:0] req1_rs1, req1_rs2, req1_immediate;
   logic [4:0]      req0_rd, req1_rd;
   logic            req0_imm, req1_imm;
   logic            rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [XLEN-1:0] rsp_result;
   logic            rsp_branch, rsp_illegal;
   logic [4:0]      rsp_rd;
   logic [1:0]      alu_unit;
   logic [2:0]      alu_sub_unit;
   logic [3:0]      alu_sel;
   logic [XLEN-1:0] alu_rs1, alu_rs2, alu_immediate, alu_result;
   logic [4:0]      alu_rd;
   logic            alu_imm, alu_ok, alu_result_v, alu_branch;
   logic [XLEN-1:0] opb;

   int   checks = 0;
   int   passes = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   alu_arbiter #(.XLEN(XLEN)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_unit(req0_unit), .req0_sub_unit(req0_sub_unit), .req0_sel(req0_sel),
      .req0_rs1(req0_rs1), .req0_rs2(req0_rs2), .req0_immediate(req0_immediate),
      .req0_rd(req0_rd), .req0_imm(req0_imm),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_unit(req1_unit), .req1_sub_unit(req1_sub_unit), .req1_sel(req1_sel),
      .req1_rs1(req1_rs1), .req1_rs2(req1_rs2), .req1_immediate(req1_immediate),
      .req1_rd(req1_rd), .req1_imm(req1_imm),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_result(rsp_result), .rsp_branch(rsp_branch), .rsp_rd(rsp_rd),
      .rsp_illegal(rsp_illegal),
      .alu_unit(alu_unit), .alu_sub_unit(alu_sub_unit), .alu_sel(alu_sel),
      .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_immediate(alu_immediate),
      .alu_rd(alu_rd), .alu_imm(alu_imm),
      .alu_ok(alu_ok), .alu_result_v(alu_result_v), .alu_branch(alu_branch),
      .alu_result(alu_result)
   );

   always #5 clk = ~clk;

   // Behavioural ALU: unit 0 only; sub_unit 2 add/sub, sub_unit 1 beq/bne.
   always_comb begin
      alu_ok       = (alu_unit == 2'd0);
      alu_result_v = 1'b0;
      alu_result   = 32'd0;
      alu_branch   = 1'b0;
      opb          = alu_imm ? alu_immediate : alu_rs2;
      if (alu_unit == 2'd0) begin
         case (alu_sub_unit)
            3'd2: begin
               alu_result_v = 1'b1;
               alu_result   = (alu_sel == 4'd0) ? alu_rs1 + opb : alu_rs1 - opb;
            end
            3'd1: begin
               alu_result_v = 1'b1;
               alu_branch   = (alu_sel == 4'd0) ? (alu_rs1 == alu_rs2) : (alu_rs1 != alu_rs2);
            end
            default: alu_result_v = 1'b0;
         endcase
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act === expv) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
   endtask

   function automatic exp_t mk(input logic port, input logic [31:0] result, input logic branch,
                               input logic [4:0] rd, input logic illegal);
      exp_t e;
      e.port = port; e.result = result; e.branch = branch; e.rd = rd; e.illegal = illegal;
      return e;
   endfunction

   // Monitor: compare every response handshake against the scoreboard head.
   always @(negedge clk) begin
      if (!rst) begin
         if (rsp0_valid || rsp1_valid) chk("rsp_onehot", {63'd0, rsp0_valid & rsp1_valid}, 64'd0);
         if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_rsp: got response rd=%0d, expected none", rsp_rd);
            end else begin
               mon_e = exp_q.pop_front();
               chk("rsp_port",    {63'd0, rsp1_valid}, {63'd0, mon_e.port});
               chk("rsp_result",  {32'd0, rsp_result}, {32'd0, mon_e.result});
               chk("rsp_branch",  {63'd0, rsp_branch}, {63'd0, mon_e.branch});
               chk("rsp_rd",      {59'd0, rsp_rd},     {59'd0, mon_e.rd});
               chk("rsp_illegal", {63'd0, rsp_illegal},{63'd0, mon_e.illegal});
            end
         end
      end
   end

   // Drive one op on requester n, wait for its accept, then drop valid.
   task automatic issue(input int n, input logic [1:0] unit, input logic [2:0] sub,
                        input logic [3:0] sel, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] immv, input logic [4:0] rd, input logic imm,
                        input logic push, input exp_t e);
      bit got = 1'b0;
      if (push) exp_q.push_back(e);
      if (n == 0) begin
         req0_unit = unit; req0_sub_unit = sub; req0_sel = sel; req0_rs1 = rs1;
         req0_rs2 = rs2; req0_immediate = immv; req0_rd = rd; req0_imm = imm; req0_valid = 1'b1;
      end else begin
         req1_unit = unit; req1_sub_unit = sub; req1_sel = sel; req1_rs1 = rs1;
         req1_rs2 = rs2; req1_immediate = immv; req1_rd = rd; req1_imm = imm; req1_valid = 1'b1;
      end
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if ((n == 0 && req0_ready) || (n == 1 && req1_ready)) got = 1'b1;
      end
      if (!got) begin
         checks++;
         $display("FAIL accept_timeout: requester %0d got no ready, expected ready within 50 cycles", n);
      end else begin
         @(posedge clk);
      end
      #1;
      if (n == 0) req0_valid = 1'b0;
      else req1_valid = 1'b0;
   endtask

   // Wait until every pushed response has been taken.
   task automatic drain();
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
      if (exp_q.size() != 0) begin
         checks++;
         $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int seq[4];
      bit got;
      rst = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_unit = 2'd0; req0_sub_unit = 3'd0; req0_sel = 4'd0; req0_rs1 = 32'd0;
      req0_rs2 = 32'd0; req0_immediate = 32'd0; req0_rd = 5'd0; req0_imm = 1'b0;
      req1_unit = 2'd0; req1_sub_unit = 3'd0; req1_sel = 4'd0; req1_rs1 = 32'd0;
      req1_rs2 = 32'd0; req1_immediate = 32'd0; req1_rd = 5'd0; req1_imm = 1'b0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;

      // Reset state with both requesters asserting valid.
      repeat (2) @(negedge clk);
      chk("rst_req0_ready", {63'd0, req0_ready}, 64'd0);
      chk("rst_req1_ready", {63'd0, req1_ready}, 64'd0);
      chk("rst_rsp0_valid", {63'd0, rsp0_valid}, 64'd0);
      chk("rst_rsp1_valid", {63'd0, rsp1_valid}, 64'd0);
      chk("rst_rsp_result", {32'd0, rsp_result}, 64'd0);
      chk("rst_alu_rs1",    {32'd0, alu_rs1},    64'd0);
      chk("rst_alu_rd",     {59'd0, alu_rd},     64'd0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(posedge clk); #1 rst = 1'b0;

      // req0 add 5+7: response visible after the second edge from accept.
      issue(0, 2'd0, 3'd2, 4'd0, 32'd5, 32'd7, 32'd0, 5'd1, 1'b0, 1'b1, mk(1'b0, 32'd12, 1'b0, 5'd1, 1'b0));
      chk("lat_alu_rs1",     {32'd0, alu_rs1}, 64'd5);
      chk("lat_alu_sub",     {61'd0, alu_sub_unit}, 64'd2);
      chk("lat_exec_valid",  {63'd0, rsp0_valid}, 64'd0);
      @(posedge clk); #1;
      chk("lat_rsp0_valid",  {63'd0, rsp0_valid}, 64'd1);
      chk("lat_rsp1_valid",  {63'd0, rsp1_valid}, 64'd0);
      chk("lat_rsp_result",  {32'd0, rsp_result}, 64'd12);
      @(posedge clk); #1;
      chk("lat_valid_drop",  {63'd0, rsp0_valid}, 64'd0);
      chk("hold_alu_rs1",    {32'd0, alu_rs1}, 64'd5);

      // Immediate operand, subtract, branch taken and not taken.
      issue(1, 2'd0, 3'd2, 4'd0, 32'd100, 32'd999, 32'd23, 5'd2, 1'b1, 1'b1, mk(1'b1, 32'd123, 1'b0, 5'd2, 1'b0));
      issue(0, 2'd0, 3'd2, 4'd1, 32'd20, 32'd7, 32'd0, 5'd6, 1'b0, 1'b1, mk(1'b0, 32'd13, 1'b0, 5'd6, 1'b0));
      issue(1, 2'd0, 3'd1, 4'd0, 32'd9, 32'd9, 32'd0, 5'd17, 1'b0, 1'b1, mk(1'b1, 32'd0, 1'b1, 5'd17, 1'b0));
      issue(0, 2'd0, 3'd1, 4'd0, 32'd9, 32'd8, 32'd0, 5'd4, 1'b0, 1'b1, mk(1'b0, 32'd0, 1'b0, 5'd4, 1'b0));
      drain();

      // Stalled response for 5 cycles, then an illegal op on req1.
      rsp0_ready = 1'b0;
      issue(0, 2'd0, 3'd2, 4'd0, 32'd2, 32'd3, 32'd0, 5'd3, 1'b0, 1'b1, mk(1'b0, 32'd5, 1'b0, 5'd3, 1'b0));
      @(posedge clk); #1;
      repeat (5) begin
         @(negedge clk);
         chk("stall_rsp0_valid", {63'd0, rsp0_valid}, 64'd1);
         chk("stall_rsp_result", {32'd0, rsp_result}, 64'd5);
         chk("stall_rsp_rd",     {59'd0, rsp_rd}, 64'd3);
         chk("stall_req_ready",  {62'd0, req1_ready, req0_ready}, 64'd0);
      end
      @(posedge clk); #1;
      exp_q.push_back(mk(1'b1, 32'd0, 1'b0, 5'd7, 1'b1));
      req1_unit = 2'd1; req1_sub_unit = 3'd2; req1_sel = 4'd0; req1_rs1 = 32'd1;
      req1_rs2 = 32'd1; req1_rd = 5'd7; req1_imm = 1'b0; req1_valid = 1'b1;
      rsp0_ready = 1'b1;
      @(negedge clk);
      chk("resp_req1_ready", {63'd0, req1_ready}, 64'd0);
      @(posedge clk); #1;
      chk("idle_rsp0_valid", {63'd0, rsp0_valid}, 64'd0);
      chk("idle_req1_ready", {63'd0, req1_ready}, 64'd1);
      @(posedge clk); #1 req1_valid = 1'b0;
      drain();

      // Reset during EXEC drops the op; a req0 waiting through reset is taken
      // on the first edge after release.
      issue(0, 2'd0, 3'd2, 4'd0, 32'd40, 32'd2, 32'd0, 5'd9, 1'b0, 1'b0, mk(1'b0, 32'd0, 1'b0, 5'd0, 1'b0));
      rst = 1'b1;
      exp_q.push_back(mk(1'b0, 32'd2, 1'b0, 5'd11, 1'b0));
      req0_unit = 2'd0; req0_sub_unit = 3'd2; req0_sel = 4'd0; req0_rs1 = 32'd1;
      req0_rs2 = 32'd1; req0_rd = 5'd11; req0_imm = 1'b0; req0_valid = 1'b1;
      @(negedge clk);
      chk("mid_rst_rsp0_valid", {63'd0, rsp0_valid}, 64'd0);
      chk("mid_rst_rsp_result", {32'd0, rsp_result}, 64'd0);
      chk("mid_rst_alu_rs1",    {32'd0, alu_rs1}, 64'd0);
      chk("mid_rst_req0_ready", {63'd0, req0_ready}, 64'd0);
      #1 rst = 1'b0;
      #1 chk("post_rst_req0_ready", {63'd0, req0_ready}, 64'd1);
      @(posedge clk); #1;
      chk("post_rst_alu_rd",  {59'd0, alu_rd}, 64'd11);
      chk("post_rst_alu_rs1", {32'd0, alu_rs1}, 64'd1);
      req0_valid = 1'b0;
      drain();

      // Both requesters valid continuously from a fresh reset.
      rst = 1'b1;
      @(negedge clk); #1 rst = 1'b0;
`ifdef ALU_ARBITER_RR_EN
      seq[0] = 0; seq[1] = 1; seq[2] = 0; seq[3] = 1;
`else
      seq[0] = 0; seq[1] = 0; seq[2] = 0; seq[3] = 0;
`endif
      for (int i = 0; i < 4; i++) begin
         if (seq[i] == 0) exp_q.push_back(mk(1'b0, 32'd3, 1'b0, 5'd10, 1'b0));
         else exp_q.push_back(mk(1'b1, 32'd7, 1'b0, 5'd20, 1'b0));
      end
      req0_unit = 2'd0; req0_sub_unit = 3'd2; req0_sel = 4'd0; req0_rs1 = 32'd1;
      req0_rs2 = 32'd2; req0_rd = 5'd10; req0_imm = 1'b0; req0_valid = 1'b1;
      req1_unit = 2'd0; req1_sub_unit = 3'd2; req1_sel = 4'd0; req1_rs1 = 32'd3;
      req1_rs2 = 32'd4; req1_rd = 5'd20; req1_imm = 1'b0; req1_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         got = 1'b0;
         for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) got = 1'b1;
         end
         if (!got) begin
            checks++;
            $display("FAIL arb_timeout: no grant for accept %0d, expected a grant", i);
         end else begin
            chk("arb_ready_onehot", {63'd0, req0_ready & req1_ready}, 64'd0);
            chk("arb_grant", {63'd0, req1_ready}, seq[i]);
            @(posedge clk);
         end
      end
      #1 req0_valid = 1'b0; req1_valid = 1'b0;
      drain();
      chk("queue_empty", exp_q.size(), 64'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
